// File: rtl/dft_mode_sequencer.sv
// -----------------------------------------------------------------------------
// dft_mode_sequencer
//
// Upstream control stage for the DFT clock controller. Takes mode-change
// requests over a valid/ready handshake and applies each change only while the
// core clock is gated off. The sequence is drain, switch, settle, resume, so
// the downstream clock mux only ever switches while the core is idle.
// Everything runs on func_clk.
//
// Ports
//   func_clk        in   functional clock, all logic on the rising edge
//   rst_n           in   asynchronous, active-low reset
//   mode_req[1:0]   in   requested mode: 00 func, 01 scan, 10 jtag, 11 bist
//   bypass_req      in   requested dft_bypass value, qualified with mode_req
//   mode_req_valid  in   request valid
//   mode_req_ready  out  sequencer can accept a request (FSM in IDLE)
//   scan_en_req     in   raw scan enable from the tester pad
//   test_mode[1:0]  out  registered mode to the clock controller
//   dft_bypass      out  registered bypass to the clock controller
//   scan_enable     out  qualified, registered scan enable
//   core_clk_en     out  enable to the core clock ICG (0 = core clock stopped)
//   busy            out  drain/switch/settle sequence in progress
//   mode_ack        out  one-cycle pulse when the requested mode is in effect
//   fsm_state[2:0]  out  current FSM state, for debug and checkers
//
// Handshake: a request transfers on a rising edge where mode_req_valid and
// mode_req_ready are both high. The requester holds valid, mode_req and
// bypass_req stable until that edge; ready never depends on valid.
// -----------------------------------------------------------------------------
module dft_mode_sequencer #(
    parameter int unsigned STOP_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       func_clk,
    input  logic       rst_n,
    input  logic [1:0] mode_req,
    input  logic       bypass_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    input  logic       scan_en_req,
    output logic [1:0] test_mode,
    output logic       dft_bypass,
    output logic       scan_enable,
    output logic       core_clk_en,
    output logic       busy,
    output logic       mode_ack,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SWITCH = 3'd2,
        SETTLE = 3'd3,
        RESUME = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on entry, so the last cycle of
    // a phase lasting N cycles sees the counter at N-1.
    localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       hold_mode;
    logic             hold_bypass;

    logic accept;
    logic same_req;
    logic start_seq;
    logic busy_nxt;

    assign mode_req_ready = (state == IDLE);
    assign accept         = mode_req_valid & mode_req_ready;
    assign same_req       = ({mode_req, bypass_req} == {test_mode, dft_bypass});
    // A request that changes the mode starts the clock-stop sequence.
    assign start_seq      = accept & ~same_req;
    assign fsm_state      = state;

    // ------------------------------------------------------------------
    // State and counter register
    // ------------------------------------------------------------------
    always_ff @(posedge func_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    // An unchanged request needs no clock stop; acknowledge it.
                    state_nxt = same_req ? RESUME : DRAIN;
                end
            end
            DRAIN: begin
                // The counter only advances below the terminal count, so it
                // saturates rather than wraps.
                if (cnt >= STOP_LAST) begin
                    state_nxt = SWITCH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SWITCH: begin
                cnt_nxt   = '0;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt >= SETTLE_LAST) begin
                    state_nxt = RESUME;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESUME: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // busy and core_clk_en are registered from the next state so the ICG
    // enable comes straight from a flop with no decode glitches.
    assign busy_nxt = (state_nxt == DRAIN) || (state_nxt == SWITCH) ||
                      (state_nxt == SETTLE);

    always_ff @(posedge func_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            core_clk_en <= 1'b1;
            mode_ack    <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            core_clk_en <= ~busy_nxt;
            mode_ack    <= (state_nxt == RESUME);
        end
    end

    // ------------------------------------------------------------------
    // Request capture and mode registers
    // ------------------------------------------------------------------
    always_ff @(posedge func_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_mode   <= 2'b00;
            hold_bypass <= 1'b0;
        end else if (accept) begin
            hold_mode   <= mode_req;
            hold_bypass <= bypass_req;
        end
    end

    // test_mode and dft_bypass move together on the edge leaving SWITCH, which
    // sits in the middle of the clock-stopped window.
    always_ff @(posedge func_clk or negedge rst_n) begin
        if (!rst_n) begin
            test_mode  <= 2'b00;
            dft_bypass <= 1'b0;
        end else if (state == SWITCH) begin
            test_mode  <= hold_mode;
            dft_bypass <= hold_bypass;
        end
    end

    // ------------------------------------------------------------------
    // Scan enable qualification
    // ------------------------------------------------------------------
    // Only passes through in scan mode while idle; dropped on the same edge a
    // mode change starts so scan shifting stops before the clock is drained.
    always_ff @(posedge func_clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_enable <= 1'b0;
        end else begin
            scan_enable <= scan_en_req & (test_mode == 2'b01) &
                           (state == IDLE) & ~start_seq;
        end
    end

endmodule

// File: tb/tb_dft_mode_sequencer.sv
module tb_dft_mode_sequencer;

  localparam int S = 8;
  localparam int T = 16;

  logic       func_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_req = 2'b00;
  logic       bypass_req = 1'b0;
  logic       mode_req_valid = 1'b0;
  logic       mode_req_ready;
  logic       scan_en_req = 1'b0;
  logic [1:0] test_mode;
  logic       dft_bypass;
  logic       scan_enable;
  logic       core_clk_en;
  logic       busy;
  logic       mode_ack;
  logic [2:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock ----------------
  always #5 func_clk = ~func_clk;

  dft_mode_sequencer #(
    .STOP_CYCLES(S),
    .SETTLE_CYCLES(T),
    .CNT_W(8)
  ) dut (
    .func_clk(func_clk),
    .rst_n(rst_n),
    .mode_req(mode_req),
    .bypass_req(bypass_req),
    .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready),
    .scan_en_req(scan_en_req),
    .test_mode(test_mode),
    .dft_bypass(dft_bypass),
    .scan_enable(scan_enable),
    .core_clk_en(core_clk_en),
    .busy(busy),
    .mode_ack(mode_ack),
    .fsm_state(fsm_state)
  );

  // Observed outputs packed as {test_mode, bypass, scan_en, clk_en, busy, ack, ready}
  logic [7:0] obs;
  assign obs = {test_mode, dft_bypass, scan_enable, core_clk_en, busy, mode_ack,
                mode_req_ready};

  // ---------------- reference model ----------------
  // Timeline model: t counts cycles since the accept cycle (accept cycle = 0),
  // t < 0 means no request outstanding. A changing request keeps the core
  // clock off for cycles 1..S+T+1, applies the new mode from cycle S+2 and
  // acknowledges in cycle S+T+2; an unchanged one acknowledges in cycle 1.
  int         t;
  logic [1:0] m_mode;
  logic       m_byp;
  logic [1:0] p_mode;
  logic       p_byp;
  logic       m_change;
  logic       m_scan;
  logic       m_accepted;

  function automatic int seq_len();
    return m_change ? (S + T + 2) : 1;
  endfunction

  task automatic model_reset();
    t = -1;
    m_mode = 2'b00;
    m_byp = 1'b0;
    p_mode = 2'b00;
    p_byp = 1'b0;
    m_change = 1'b0;
    m_scan = 1'b0;
    m_accepted = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    logic idle;
    logic acc;
    logic chg;
    idle = (t < 0);
    acc = idle && mode_req_valid;
    chg = ({mode_req, bypass_req} != {m_mode, m_byp});
    m_scan = scan_en_req && (m_mode == 2'b01) && idle && !(acc && chg);
    m_accepted = acc;
    if (acc) begin
      t = 1;
      p_mode = mode_req;
      p_byp = bypass_req;
      m_change = chg;
    end else if (t >= 0) begin
      if (t == seq_len()) t = -1;
      else t++;
    end
    if (t == S + 2 && m_change) begin
      m_mode = p_mode;
      m_byp = p_byp;
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic off;
    logic ack;
    off = m_change && (t >= 1) && (t <= S + T + 1);
    ack = (t >= 1) && (t == seq_len());
    return {m_mode, m_byp, m_scan, !off, off, ack, (t < 0)};
  endfunction

  // ---------------- drivers ----------------
  // One clock: model steps, DUT clocks, then we sit at the falling edge where
  // outputs are sampled and new inputs are driven.
  task automatic tick();
    model_edge();
    @(posedge func_clk);
    @(negedge func_clk);
  endtask

  task automatic apply_reset();
    mode_req_valid = 1'b0;
    scan_en_req = 1'b0;
    @(negedge func_clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge func_clk);
    @(negedge func_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int ack_seen;
    ack_seen = 0;
    apply_reset();
    vectors++;
    if (obs !== 8'b00_0_0_1_0_0_1) begin
      miscompares++;
      $display("FAIL reset_values got=%b exp=%b", obs, 8'b00_0_0_1_0_0_1);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mode_ack) ack_seen++;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (ack_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_no_ack got=%0d exp=0", ack_seen);
    end
  endtask

  task automatic test_same();
    int ack_cyc;
    int clk_off;
    ack_cyc = -1;
    clk_off = 0;
    mode_req = 2'b00;
    bypass_req = 1'b0;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL same_req cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (mode_ack && ack_cyc < 0) ack_cyc = i;
      if (!core_clk_en) clk_off++;
      tick();
    end
    vectors++;
    if (ack_cyc !== 1) begin
      miscompares++;
      $display("FAIL same_ack_latency got=%0d exp=1", ack_cyc);
    end
    vectors++;
    if (clk_off !== 0) begin
      miscompares++;
      $display("FAIL same_clk_stop got=%0d exp=0", clk_off);
    end
  endtask

  task automatic test_change();
    int ack_cyc;
    int low_cnt;
    int first_new;
    logic clk_at_change;
    ack_cyc = -1;
    low_cnt = 0;
    first_new = -1;
    clk_at_change = 1'b1;
    mode_req = 2'b01;
    bypass_req = 1'b0;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    for (int i = 1; i <= S + T + 6; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL change_seq cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (mode_ack && ack_cyc < 0) ack_cyc = i;
      if (!core_clk_en) low_cnt++;
      if (test_mode == 2'b01 && first_new < 0) begin
        first_new = i;
        clk_at_change = core_clk_en;
      end
      tick();
    end
    vectors++;
    if (low_cnt !== S + T + 1) begin
      miscompares++;
      $display("FAIL change_low_cycles got=%0d exp=%0d", low_cnt, S + T + 1);
    end
    vectors++;
    if (ack_cyc !== S + T + 2) begin
      miscompares++;
      $display("FAIL change_ack_latency got=%0d exp=%0d", ack_cyc, S + T + 2);
    end
    vectors++;
    if (first_new < 2 || clk_at_change !== 1'b0) begin
      miscompares++;
      $display("FAIL change_mode_while_stopped cyc=%0d clk_en=%b exp=0",
               first_new, clk_at_change);
    end
  endtask

  task automatic test_scan();
    // Currently in mode 01 and idle: scan enable follows with one cycle delay.
    scan_en_req = 1'b1;
    tick();
    vectors++;
    if (scan_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_follow_rise got=%b exp=1", scan_enable);
    end
    scan_en_req = 1'b0;
    tick();
    vectors++;
    if (scan_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_follow_fall got=%b exp=0", scan_enable);
    end
    for (int i = 0; i < 24; i++) begin
      scan_en_req = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL scan_toggle cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    // Switch to bist with scan still requested: scan enable must drop at once.
    scan_en_req = 1'b1;
    mode_req = 2'b11;
    bypass_req = 1'b0;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    for (int i = 1; i <= S + T + 8; i++) begin
      vectors++;
      if (scan_enable !== 1'b0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL scan_leave cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int ack1;
    int acc2;
    int ack2;
    logic hold;
    ack1 = -1;
    acc2 = -1;
    ack2 = -1;
    scan_en_req = 1'b0;
    mode_req = 2'b01;
    bypass_req = 1'b0;
    mode_req_valid = 1'b1;
    tick();
    // Second request held from the next cycle while the first is in flight.
    mode_req = 2'b10;
    bypass_req = 1'b1;
    hold = 1'b1;
    for (int i = 1; i <= 2 * (S + T + 4); i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_seq cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (mode_ack && ack1 < 0) ack1 = i;
      else if (mode_ack && acc2 >= 0 && ack2 < 0) ack2 = i;
      if (hold && mode_req_ready && acc2 < 0) acc2 = i;
      tick();
      if (m_accepted && hold && i >= 1) begin
        mode_req_valid = 1'b0;
        hold = 1'b0;
      end
    end
    vectors++;
    if (acc2 !== ack1 + 1 || ack1 !== S + T + 2) begin
      miscompares++;
      $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc2, S + T + 3);
    end
    vectors++;
    if ({test_mode, dft_bypass} !== 3'b10_1 || ack2 < 0) begin
      miscompares++;
      $display("FAIL b2b_final_mode got=%b ack2=%0d exp=101", {test_mode, dft_bypass},
               ack2);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    apply_reset();
    mode_req = 2'b11;
    bypass_req = 1'b0;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    // Run into the middle of SETTLE (mode already switched to 11).
    for (int i = 1; i < S + 6; i++) tick();
    vectors++;
    if (test_mode !== 2'b11 || core_clk_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_pre got=%b exp=11/0", {test_mode, core_clk_en});
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 8'b00_0_0_1_0_0_1) begin
      miscompares++;
      $display("FAIL rstmid_async got=%b exp=%b", obs, 8'b00_0_0_1_0_0_1);
    end
    @(negedge func_clk);
    rst_n = 1'b1;
    for (int i = 0; i < S + T + 6; i++) begin
      tick();
      if (mode_ack) acks++;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL rstmid_after cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (acks !== 0 || test_mode !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_no_ack acks=%0d mode=%b exp=0/00", acks, test_mode);
    end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      scan_en_req = 1'($urandom_range(0, 1));
      if (!hold && $urandom_range(0, 5) == 0) begin
        hold = 1'b1;
        mode_req_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          mode_req = m_mode;
          bypass_req = m_byp;
        end else begin
          mode_req = 2'($urandom_range(0, 3));
          bypass_req = 1'($urandom_range(0, 1));
        end
      end
      tick();
      if (m_accepted) begin
        mode_req_valid = 1'b0;
        hold = 1'b0;
      end
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_same();
    test_change();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case something above never returns.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/dft_mode_sequencer.md
Name: dft_mode_sequencer

Overview:
Upstream control stage for the DFT clock controller; generates its test_mode, dft_bypass and scan_enable inputs.
Mode requests arrive over a valid/ready handshake. Each change is applied only while the core clock is gated off: drain, switch, settle, resume.
This keeps the controller's simple clock mux glitch-safe, because mode changes happen only while the core is idle.
Runs entirely on func_clk.

Parameters:
STOP_CYCLES, 8, cycles core_clk_en is held low before the mode switch (must be >= 1)
SETTLE_CYCLES, 16, cycles core_clk_en is held low after the mode switch (must be >= 1)
CNT_W, 8, counter width; must hold max(STOP_CYCLES, SETTLE_CYCLES)

Ports:
func_clk  input  1  functional clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
mode_req  input  2  requested mode: 00 func, 01 scan, 10 jtag, 11 bist
bypass_req  input  1  requested dft_bypass value, qualified with mode_req
mode_req_valid  input  1  request valid; held with data stable until accepted
mode_req_ready  output  1  sequencer can accept a request
scan_en_req  input  1  raw scan enable from tester pad
test_mode  output  2  registered mode to the clock controller
dft_bypass  output  1  registered bypass to the clock controller
scan_enable  output  1  qualified, registered scan enable
core_clk_en  output  1  enable to the core clock ICG (0 = core clock stopped)
busy  output  1  sequence in progress
mode_ack  output  1  one-cycle pulse when the requested mode is in effect

Behaviour:
- Reset values: test_mode=00, dft_bypass=0, scan_enable=0, core_clk_en=1, busy=0, mode_ack=0, FSM=IDLE, counter=0.
- mode_req_ready = (state==IDLE). Accept = mode_req_valid & mode_req_ready on a rising edge. mode_req and bypass_req are captured into hold registers at accept.
- FSM states: IDLE, DRAIN, SWITCH, SETTLE, RESUME.
- IDLE, accept with {mode_req,bypass_req} == {test_mode,dft_bypass}: no clock stop. Next cycle goes to RESUME with mode_ack=1, then back to IDLE.
- IDLE, accept with a different value: go to DRAIN. core_clk_en=0 and busy=1 from the next cycle. Counter loads 0.
- DRAIN: counter increments each cycle. After STOP_CYCLES cycles in DRAIN, go to SWITCH.
- SWITCH: lasts exactly 1 cycle. test_mode and dft_bypass load the hold registers on the edge leaving SWITCH. Counter clears. Go to SETTLE.
- SETTLE: after SETTLE_CYCLES cycles, go to RESUME.
- RESUME: lasts 1 cycle. core_clk_en=1, mode_ack=1, busy=0. Go to IDLE; ready is 1 again the following cycle.
- Changing request timing: core_clk_en low for exactly STOP_CYCLES+1+SETTLE_CYCLES cycles. Accept to mode_ack = STOP_CYCLES+SETTLE_CYCLES+2 cycles.
- core_clk_en is 0 whenever test_mode or dft_bypass changes. The two change on the same edge, never separately.
- scan_enable: registered from scan_en_req & (test_mode==01) & (state==IDLE); 1-cycle latency from scan_en_req.
- scan_enable is forced to 0 on the edge the FSM leaves IDLE for DRAIN. It stays 0 through SETTLE and RESUME.
- scan_enable is 0 in every mode other than 01.
- busy=1 in DRAIN, SWITCH and SETTLE. busy is 0 in RESUME and IDLE, so it does not overlap mode_ack.
- mode_req_valid asserted while the FSM is not in IDLE is ignored (ready=0). The request is accepted on the first IDLE cycle if still held.
- Back-to-back requests: a new accept is possible at the earliest 1 cycle after RESUME.
- Reset mid-sequence, any state: immediate asynchronous return to reset values, including core_clk_en=1 and test_mode=00. No mode_ack is generated.
- Counters saturate at the terminal count and never wrap.

Test Plan:
- Reset then idle 20 cycles -> test_mode=00, dft_bypass=0, core_clk_en=1, scan_enable=0, ready=1, no mode_ack.
- Request mode 01, bypass 0 with defaults -> core_clk_en low exactly 25 cycles; test_mode=01 updates while core_clk_en=0, between the low edge and the high edge; mode_ack 26 cycles after accept.
- Request 00/0 while already 00/0 -> core_clk_en stays 1; mode_ack 1 cycle after accept; outputs unchanged.
- In mode 01, toggle scan_en_req -> scan_enable follows 1 cycle later. Then request mode 11 -> scan_enable drops the cycle after accept and stays 0 after the switch even with scan_en_req=1.
- Hold mode_req_valid with mode 10 during an active 01 sequence -> ready=0, no capture; second request accepted the cycle after RESUME; final test_mode=10.
- Assert rst_n low during SETTLE of a 00->11 change -> outputs immediately at reset values; after release ready=1, test_mode=00, no mode_ack.
